// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Purpose:
//   Shares the single unified instruction/data memory of the multicycle RISC-V
//   core between the core (fetch, lw, sw) and an external loader/debug port.
//   One access is granted at a time. Writes complete in their grant cycle.
//   Reads occupy the memory for MEM_LAT+1 cycles: the grant cycle plus
//   MEM_LAT wait cycles, the last of which returns the data. The core is
//   stalled while its access is pending. A starvation counter guarantees the
//   external port eventually wins against a continuously requesting core.
//
// Parameters:
//   AW          address width
//   DW          data width
//   MEM_LAT     memory read latency in cycles (1..4)
//   STARVE_MAX  contested core grants allowed before ext is forced to win
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous, active-low reset
//   core_req_i     core access request, held while core_stall_o=1
//   core_we_i      core write enable (1=sw, 0=fetch/lw)
//   core_addr_i    core byte address
//   core_wdata_i   core write data
//   core_rdata_o   core read data, valid in the core completion cycle
//   core_stall_o   core access not completing this cycle
//   ext_req_i      external request, held until ext_gnt_o
//   ext_we_i       external write enable
//   ext_addr_i     external address
//   ext_wdata_i    external write data
//   ext_gnt_o      pulse in the cycle the ext access is issued to memory
//   ext_rvalid_o   pulse when ext read data is valid
//   ext_rdata_o    ext read data, valid with ext_rvalid_o
//   mem_en_o       memory access strobe (grant cycle)
//   mem_we_o       memory write enable, qualified by mem_en_o
//   mem_addr_o     memory address
//   mem_wdata_o    memory write data
//   mem_rdata_i    memory read data, valid MEM_LAT cycles after a read grant
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic [DW-1:0] core_rdata_o,
  output logic          core_stall_o,

  input  logic          ext_req_i,
  input  logic          ext_we_i,
  input  logic [AW-1:0] ext_addr_i,
  input  logic [DW-1:0] ext_wdata_i,
  output logic          ext_gnt_o,
  output logic          ext_rvalid_o,
  output logic [DW-1:0] ext_rdata_o,

  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int CW = 3;                          // holds MEM_LAT up to 4
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] LAT_LOAD  = CW'(MEM_LAT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_ext_q, owner_ext_d;   // 1 = outstanding read belongs to ext
  logic [SW-1:0] starve_q, starve_d;

  logic in_idle;
  logic core_win;
  logic ext_win;
  logic rd_return;
  logic core_done;
  logic run;

  // reset is active-low: the arbiter only acts while it is high.
  assign run = reset;

  // ---------------------------------------------------------------------------
  // Grant decision. Only made in IDLE; the return cycle of a read never grants.
  // Core wins a contest until it has won STARVE_MAX contested grants in a row.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    core_win  = in_idle & core_req_i & (~ext_req_i | (starve_q < STARVE_LIM));
    ext_win   = in_idle & ext_req_i & ~core_win;
    rd_return = (state_q == ST_RD_WAIT) & (cnt_q == CNT_ONE);
    core_done = (core_win & core_we_i) | (rd_return & ~owner_ext_q);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_ext_d = owner_ext_q;
    starve_d    = starve_q;

    case (state_q)
      ST_IDLE: begin
        if (core_win) begin
          // Only contested wins count toward starving the ext port.
          if (ext_req_i) begin
            starve_d = starve_q + SW'(1);
          end
          if (!core_we_i) begin
            state_d     = ST_RD_WAIT;
            cnt_d       = LAT_LOAD;
            owner_ext_d = 1'b0;
          end
        end else if (ext_win) begin
          starve_d = '0;
          if (!ext_we_i) begin
            state_d     = ST_RD_WAIT;
            cnt_d       = LAT_LOAD;
            owner_ext_d = 1'b1;
          end
        end
      end

      ST_RD_WAIT: begin
        if (rd_return) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset also discards any outstanding read, so an aborted
  // read never produces a completion.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_ext_q <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_ext_q <= owner_ext_d;
      starve_q    <= starve_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Strobes and the memory address/data bus are forced low while
  // reset is asserted, independent of the current requests.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    core_stall_o = 1'b0;
    ext_gnt_o    = 1'b0;
    ext_rvalid_o = 1'b0;

    if (run) begin
      if (core_win) begin
        mem_en_o    = 1'b1;
        mem_we_o    = core_we_i;
        mem_addr_o  = core_addr_i;
        mem_wdata_o = core_wdata_i;
      end else if (ext_win) begin
        mem_en_o    = 1'b1;
        mem_we_o    = ext_we_i;
        mem_addr_o  = ext_addr_i;
        mem_wdata_o = ext_wdata_i;
      end
      core_stall_o = core_req_i & ~core_done;
      ext_gnt_o    = ext_win;
      ext_rvalid_o = rd_return & owner_ext_q;
    end
  end

  // Read data is a straight pass-through; it is only meaningful in the
  // completion cycle of the matching requester.
  assign core_rdata_o = mem_rdata_i;
  assign ext_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // ---------------- DUT 1: MEM_LAT=2, STARVE_MAX=4 ----------------
  logic        c_req, c_we, e_req, e_we;
  logic [31:0] c_addr, c_wdata, e_addr, e_wdata;
  logic [31:0] c_rdata, e_rdata;
  logic        c_stall, e_gnt, e_rvalid;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .core_req_i(c_req), .core_we_i(c_we), .core_addr_i(c_addr), .core_wdata_i(c_wdata),
    .core_rdata_o(c_rdata), .core_stall_o(c_stall),
    .ext_req_i(e_req), .ext_we_i(e_we), .ext_addr_i(e_addr), .ext_wdata_i(e_wdata),
    .ext_gnt_o(e_gnt), .ext_rvalid_o(e_rvalid), .ext_rdata_o(e_rdata),
    .mem_en_o(m_en), .mem_we_o(m_we), .mem_addr_o(m_addr), .mem_wdata_o(m_wdata),
    .mem_rdata_i(m_rdata)
  );

  // Memory model: 2-cycle read latency, write on grant edge.
  logic [31:0] mem [0:255];
  logic [31:0] p0, p1;
  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr[9:2]] <= m_wdata;
    if (m_en && !m_we) p0 <= m_addr;
    p1 <= p0;
  end
  assign m_rdata = mem[p1[9:2]];

  // ---------------- DUT 2: MEM_LAT=1 ----------------
  logic        c2_req, c2_we;
  logic [31:0] c2_addr, c2_rdata;
  logic        c2_stall, e2_gnt, e2_rvalid;
  logic [31:0] e2_rdata;
  logic        m2_en, m2_we;
  logic [31:0] m2_addr, m2_wdata, m2_rdata;
  logic [31:0] q2;

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut2 (
    .clk(clk), .reset(reset),
    .core_req_i(c2_req), .core_we_i(c2_we), .core_addr_i(c2_addr), .core_wdata_i(32'h0),
    .core_rdata_o(c2_rdata), .core_stall_o(c2_stall),
    .ext_req_i(1'b0), .ext_we_i(1'b0), .ext_addr_i(32'h0), .ext_wdata_i(32'h0),
    .ext_gnt_o(e2_gnt), .ext_rvalid_o(e2_rvalid), .ext_rdata_o(e2_rdata),
    .mem_en_o(m2_en), .mem_we_o(m2_we), .mem_addr_o(m2_addr), .mem_wdata_o(m2_wdata),
    .mem_rdata_i(m2_rdata)
  );

  // 1-cycle memory whose content is a fixed function of the address.
  always @(posedge clk) if (m2_en && !m2_we) q2 <= m2_addr;
  assign m2_rdata = q2 ^ 32'h5A5A_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'h0050_0113;   // byte address 0x10
    mem[8'h10] = 32'h1234_5678;   // byte address 0x40
    p0 = 32'h0; p1 = 32'h0; q2 = 32'h0;

    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = 32'h0;
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h40; e_wdata = 32'h0;
    c2_req = 1'b0; c2_we = 1'b0; c2_addr = 32'h0;

    // ---- Reset: strobes low even with requests pending ----
    tick(); tick();
    at_neg();
    check("rst_mem_en",     {31'b0, m_en},     32'h0);
    check("rst_core_stall", {31'b0, c_stall},  32'h0);
    check("rst_ext_gnt",    {31'b0, e_gnt},    32'h0);
    check("rst_mem_addr",   m_addr,            32'h0);
    tick();
    reset = 1'b1; c_req = 1'b0; e_req = 1'b0;
    at_neg();
    check("idle_mem_en",    {31'b0, m_en},     32'h0);
    check("idle_stall",     {31'b0, c_stall},  32'h0);
    tick();

    // ---- Test 1: core read of 0x10 ----
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    at_neg();
    check("t1_t0_mem_en",   {31'b0, m_en},     32'h1);
    check("t1_t0_addr",     m_addr,            32'h10);
    check("t1_t0_stall",    {31'b0, c_stall},  32'h1);
    tick(); at_neg();
    check("t1_t1_mem_en",   {31'b0, m_en},     32'h0);
    check("t1_t1_stall",    {31'b0, c_stall},  32'h1);
    tick(); at_neg();
    check("t1_t2_stall",    {31'b0, c_stall},  32'h0);
    check("t1_t2_rdata",    c_rdata,           32'h0050_0113);
    tick();
    c_req = 1'b0;

    // ---- Test 2: core write then read back ----
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h20; c_wdata = 32'hDEAD_BEEF;
    at_neg();
    check("t2_wr_mem_en",   {31'b0, m_en},     32'h1);
    check("t2_wr_mem_we",   {31'b0, m_we},     32'h1);
    check("t2_wr_wdata",    m_wdata,           32'hDEAD_BEEF);
    check("t2_wr_stall",    {31'b0, c_stall},  32'h0);
    tick();
    c_we = 1'b0;
    at_neg();
    check("t2_rd_stall0",   {31'b0, c_stall},  32'h1);
    tick(); tick(); at_neg();
    check("t2_rd_stall2",   {31'b0, c_stall},  32'h0);
    check("t2_rd_rdata",    c_rdata,           32'hDEAD_BEEF);
    tick();
    c_req = 1'b0;

    // ---- Test 3: core and ext reads contend ----
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h40;
    at_neg();
    check("t3_t0_ext_gnt",  {31'b0, e_gnt},    32'h0);
    check("t3_t0_addr",     m_addr,            32'h10);
    tick(); tick(); at_neg();
    check("t3_t2_stall",    {31'b0, c_stall},  32'h0);
    check("t3_t2_ext_gnt",  {31'b0, e_gnt},    32'h0);
    check("t3_t2_rdata",    c_rdata,           32'h0050_0113);
    tick();
    c_req = 1'b0;
    at_neg();
    check("t3_t3_ext_gnt",  {31'b0, e_gnt},    32'h1);
    check("t3_t3_addr",     m_addr,            32'h40);
    tick();
    e_req = 1'b0;
    at_neg();
    check("t3_t4_rvalid",   {31'b0, e_rvalid}, 32'h0);
    tick(); at_neg();
    check("t3_t5_rvalid",   {31'b0, e_rvalid}, 32'h1);
    check("t3_t5_rdata",    e_rdata,           32'h1234_5678);
    tick();

    // ---- Test 4: starvation protection with back-to-back core writes ----
    c_req = 1'b1; c_we = 1'b1;
    e_req = 1'b1; e_we = 1'b1; e_addr = 32'h80; e_wdata = 32'hCAFE_0000;
    for (int i = 0; i < 4; i++) begin
      c_addr = 32'h100 + 32'(4 * i); c_wdata = 32'(i);
      at_neg();
      check($sformatf("t4_core%0d_stall", i), {31'b0, c_stall}, 32'h0);
      check($sformatf("t4_core%0d_gnt", i),   {31'b0, e_gnt},   32'h0);
      tick();
    end
    c_addr = 32'h110; c_wdata = 32'h4;
    at_neg();
    check("t4_ext_gnt",     {31'b0, e_gnt},    32'h1);
    check("t4_ext_stall",   {31'b0, c_stall},  32'h1);
    check("t4_ext_addr",    m_addr,            32'h80);
    check("t4_ext_we",      {31'b0, m_we},     32'h1);
    tick();
    e_req = 1'b0;
    at_neg();
    check("t4_resume_stall", {31'b0, c_stall}, 32'h0);
    check("t4_resume_addr",  m_addr,           32'h110);
    tick();
    c_req = 1'b0; c_we = 1'b0;
    at_neg();
    check("t4_ext_mem",     mem[8'h20],        32'hCAFE_0000);
    tick();

    // ---- Test 5: reset mid core read ----
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    at_neg();
    check("t5_t0_stall",    {31'b0, c_stall},  32'h1);
    tick();
    reset = 1'b0;
    at_neg();
    check("t5_rst_mem_en",  {31'b0, m_en},     32'h0);
    check("t5_rst_stall",   {31'b0, c_stall},  32'h0);
    check("t5_rst_rvalid",  {31'b0, e_rvalid}, 32'h0);
    tick();
    reset = 1'b1; c_addr = 32'h40;
    at_neg();
    check("t5_new_mem_en",  {31'b0, m_en},     32'h1);
    check("t5_new_stall",   {31'b0, c_stall},  32'h1);
    check("t5_new_addr",    m_addr,            32'h40);
    tick(); at_neg();
    check("t5_new_stall1",  {31'b0, c_stall},  32'h1);
    tick(); at_neg();
    check("t5_new_stall2",  {31'b0, c_stall},  32'h0);
    check("t5_new_rdata",   c_rdata,           32'h1234_5678);
    tick();
    c_req = 1'b0;

    // ---- Test 6: MEM_LAT=1, continuous core reads ----
    c2_req = 1'b1; c2_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c2_addr = 32'h200 + 32'(4 * i);
      at_neg();
      check($sformatf("t6_rd%0d_mem_en", i), {31'b0, m2_en},    32'h1);
      check($sformatf("t6_rd%0d_stall", i),  {31'b0, c2_stall}, 32'h1);
      tick(); at_neg();
      check($sformatf("t6_rd%0d_idle", i),   {31'b0, m2_en},    32'h0);
      check($sformatf("t6_rd%0d_done", i),   {31'b0, c2_stall}, 32'h0);
      check($sformatf("t6_rd%0d_rdata", i),  c2_rdata, (32'h200 + 32'(4 * i)) ^ 32'h5A5A_0000);
      tick();
    end
    c2_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
